// File: rtl/dot_chunk_ctrl.sv
// dot_chunk_ctrl: issues one operand-fetch request per chunk of a long dot
// product and keeps no more than MAX_OUT requests in flight. It accumulates
// the returned block-scaled chunk results into one scaled sum and offers
// that sum to the downstream normaliser on a valid/ready handshake.
module dot_chunk_ctrl #(
    parameter int DP_W    = 21,
    parameter int CNT_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic        [CNT_W-1:0]         i_num_chunks,
    output logic                            o_busy,
    output logic                            o_req_valid,
    output logic        [CNT_W-1:0]         o_req_idx,
    input  logic                            i_req_ready,
    input  logic                            i_dp_valid,
    input  logic signed [DP_W-1:0]          i_dp,
    input  logic        [7:0]               i_dp_scale,
    output logic                            o_res_valid,
    input  logic                            i_res_ready,
    output logic signed [DP_W+CNT_W-1:0]    o_res,
    output logic        [7:0]               o_res_scale
);

    // Accumulator width is fixed by the chunk-result width and chunk count.
    localparam int ACC_W = DP_W + CNT_W;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic        [1:0]       state;
    logic        [CNT_W-1:0] num_chunks;
    logic        [CNT_W-1:0] issued;
    logic        [CNT_W-1:0] received;
    logic        [OUT_W-1:0] outstanding;

    logic signed [ACC_W-1:0] acc_p1;
    logic        [7:0]       acc_scale_p1;

    logic signed [ACC_W-1:0] dp_ext_p0;
    logic signed [ACC_W-1:0] acc_sum_p0;
    logic        [7:0]       acc_scale_p0;
    logic        [7:0]       shift_p0;

    logic                    req_fire;
    logic                    vld_p0;
    logic                    last_result;

    // Arithmetic right shift; shifts of ACC_W or more leave only sign fill.
    function automatic logic signed [ACC_W-1:0] sra_fill(
        input logic signed [ACC_W-1:0] v,
        input logic        [7:0]       d
    );
        if (int'(d) >= ACC_W) begin
            sra_fill = {ACC_W{v[ACC_W-1]}};
        end else begin
            sra_fill = v >>> d;
        end
    endfunction

    // Request is offered while chunks remain and a credit is free.
    always_comb begin
        o_req_valid = (state == ST_RUN) && (issued < num_chunks) && (outstanding < MAX_OUT_C);
    end

    assign o_req_idx   = issued;
    assign o_busy      = (state != ST_IDLE);
    assign o_res_valid = (state == ST_OUT);
    assign o_res       = acc_p1;
    assign o_res_scale = acc_scale_p1;

    assign req_fire = o_req_valid && i_req_ready;
    // A return with nothing outstanding is a protocol violation and is dropped.
    assign vld_p0      = (state == ST_RUN) && i_dp_valid && (outstanding != '0);
    assign last_result = (received == num_chunks - ONE_C);

    // ---- p0: align the smaller-scale operand to the larger scale and add
    always_comb begin
        dp_ext_p0    = {{CNT_W{i_dp[DP_W-1]}}, i_dp};
        shift_p0     = 8'd0;
        acc_sum_p0   = dp_ext_p0;
        acc_scale_p0 = i_dp_scale;
        if (received == '0) begin
            acc_sum_p0   = dp_ext_p0;
            acc_scale_p0 = i_dp_scale;
        end else if (acc_scale_p1 >= i_dp_scale) begin
            shift_p0     = acc_scale_p1 - i_dp_scale;
            acc_sum_p0   = acc_p1 + sra_fill(dp_ext_p0, shift_p0);
            acc_scale_p0 = acc_scale_p1;
        end else begin
            shift_p0     = i_dp_scale - acc_scale_p1;
            acc_sum_p0   = sra_fill(acc_p1, shift_p0) + dp_ext_p0;
            acc_scale_p0 = i_dp_scale;
        end
    end

    // ---- p1: sequencer state, counters and the registered accumulator
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            num_chunks   <= '0;
            issued       <= '0;
            received     <= '0;
            outstanding  <= '0;
            acc_p1       <= '0;
            acc_scale_p1 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        num_chunks   <= i_num_chunks;
                        issued       <= '0;
                        received     <= '0;
                        outstanding  <= '0;
                        acc_p1       <= '0;
                        acc_scale_p1 <= '0;
                        state        <= (i_num_chunks == '0) ? ST_OUT : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (req_fire) begin
                        issued <= issued + ONE_C;
                    end
                    if (req_fire && !vld_p0) begin
                        outstanding <= outstanding + OUT_W'(1);
                    end else if (!req_fire && vld_p0) begin
                        outstanding <= outstanding - OUT_W'(1);
                    end
                    if (vld_p0) begin
                        received     <= received + ONE_C;
                        acc_p1       <= acc_sum_p0;
                        acc_scale_p1 <= acc_scale_p0;
                        if (last_result) begin
                            state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (i_res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
